byte_demux8_loader: RTL and testbench

//  - 1-to-8 byte distributor: the write-side counterpart of the 8:1 byte read mux
//    in the TEA datapath.
//  - Accepts a byte stream with a valid/ready handshake and steers each byte into
//    one of 8 byte slots, in order.
//  - Presents the 8 slots as OUT0..OUT7, plus a completion handshake.
//  - Used to assemble 64-bit plaintext/ciphertext blocks (and key halves) ahead of
//    the TEA round engine.

---
 rtl/tea_pkg.sv | 14 +
 rtl/byte_demux8_loader.sv | 99 +++++++++
 tb/tb_byte_demux8_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tea_pkg.sv
// Shared TEA datapath types: byte slot type, slot count and loader state encoding.
package tea_pkg;

  typedef logic [7:0] byte_t;

  localparam int NSLOT = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/byte_demux8_loader.sv
// 1-to-8 byte distributor: steers an in-order byte stream into eight slots and
// presents the assembled 64-bit block behind a valid/ready completion handshake.
//
// Handshakes: a byte moves when in_valid_i & in_ready_o at a rising edge; a block
// moves when blk_valid_o & blk_ready_i at a rising edge. Neither valid may depend
// on its ready, and in_data_i must stay stable while in_valid_i waits.
module byte_demux8_loader
  import tea_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  byte_t      in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output byte_t      out0_o,
  output byte_t      out1_o,
  output byte_t      out2_o,
  output byte_t      out3_o,
  output byte_t      out4_o,
  output byte_t      out5_o,
  output byte_t      out6_o,
  output byte_t      out7_o,
  output logic [2:0] sel_o,
  output logic       blk_valid_o,
  input  logic       blk_ready_i,
  output state_e     dbg_state_o
);

  localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(NSLOT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  byte_t            slot_q [NSLOT];
  byte_t            slot_d [NSLOT];
  logic [NSLOT-1:0] slot_wen;
  logic             accept;

  // CLR gates IN_READY so a byte presented alongside a flush is never consumed.
  assign in_ready_o  = (state_q == ST_FILL) && !clr_i;
  assign accept      = in_valid_i && in_ready_o;
  assign blk_valid_o = (state_q == ST_FULL);
  assign sel_o       = sel_q;
  assign dbg_state_o = state_q;

  assign out0_o = slot_q[0];
  assign out1_o = slot_q[1];
  assign out2_o = slot_q[2];
  assign out3_o = slot_q[3];
  assign out4_o = slot_q[4];
  assign out5_o = slot_q[5];
  assign out6_o = slot_q[6];
  assign out7_o = slot_q[7];

  always_comb begin
    slot_wen = '0;
    if (accept) slot_wen[sel_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    slot_d  = slot_q;
    if (clr_i) begin
      state_d = ST_FILL;
      sel_d   = '0;
      slot_d  = '{default: '0};
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            sel_d = sel_q + 3'd1;
            if (sel_q == SEL_LAST) state_d = ST_FULL;
          end
          for (int i = 0; i < NSLOT; i++) begin
            if (slot_wen[i]) slot_d[i] = in_data_i;
          end
        end
        ST_FULL: begin
          if (blk_ready_i) state_d = ST_FILL;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      sel_q   <= '0;
      slot_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      slot_q  <= slot_d;
    end
  end

endmodule

// File: tb/tb_byte_demux8_loader.sv
// Self-checking bench for byte_demux8_loader: directed scenarios plus random gaps,
// compared against a fill-count reference model and a block scoreboard.
module tb_byte_demux8_loader;
  import tea_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [2:0] sel;
  logic       blk_valid;
  logic       blk_ready;
  state_e     dbg_state;

  logic [7:0] outs [8];
  assign outs[0] = out0; assign outs[1] = out1; assign outs[2] = out2; assign outs[3] = out3;
  assign outs[4] = out4; assign outs[5] = out5; assign outs[6] = out6; assign outs[7] = out7;

  byte_demux8_loader dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out0_o(out0), .out1_o(out1), .out2_o(out2), .out3_o(out3),
    .out4_o(out4), .out5_o(out5), .out6_o(out6), .out7_o(out7),
    .sel_o(sel), .blk_valid_o(blk_valid), .blk_ready_i(blk_ready),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: how many bytes the current block holds (8 = block complete).
  int         m_filled;
  logic [7:0] m_slot [8];
  logic [7:0] exp_q [$];
  logic [7:0] last_blk [8];

  task automatic model_reset();
    m_filled = 0;
    for (int i = 0; i < 8; i++) m_slot[i] = 8'h00;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ":blk_valid"}, blk_valid, (m_filled == 8));
    check({pfx, ":sel"}, sel, m_filled % 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s:out%0d", pfx, i), outs[i], m_slot[i]);
  endtask

  // driver: inputs are already set; check ready, take one edge, update model, check.
  task automatic cycle(input string pfx, output bit acc);
    bit rdy_exp;
    #1;
    rdy_exp = (m_filled != 8) && !clr;
    check({pfx, ":in_ready"}, in_ready, rdy_exp);
    acc = in_valid && rdy_exp;
    @(posedge clk);
    if (clr) model_reset();
    else if (m_filled == 8) begin
      if (blk_ready) m_filled = 0;
    end else if (acc) begin
      m_slot[m_filled] = in_data;
      m_filled++;
    end
    #1;
    check_all(pfx);
  endtask

  bit acc;
  int n_acc;
  int budget;
  int full_cycles;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_data = 8'h00; in_valid = 1'b0; blk_ready = 1'b0;
    model_reset();
    #3;
    check("reset:in_ready", in_ready, 1'b1);
    check_all("reset");
    check("reset:state", dbg_state, ST_FILL);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: bytes 11..88 back to back
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 * (i + 1));
      cycle("t1", acc);
    end
    check("t1:blk_valid", blk_valid, 1'b1);
    check("t1:out7", outs[7], 8'h88);

    // 2: hold AA while FULL, then a one-cycle handoff
    in_data = 8'hAA;
    for (int i = 0; i < 5; i++) cycle("t2hold", acc);
    check("t2:out0_held", outs[0], 8'h11);
    blk_ready = 1'b1;
    cycle("t2ho", acc);
    blk_ready = 1'b0;
    check("t2:blk_valid_after_ho", blk_valid, 1'b0);
    cycle("t2acc", acc);
    check("t2:aa_accepted", acc, 1'b1);
    check("t2:out0_aa", outs[0], 8'hAA);

    // 4: reach SEL=3, then CLR with a byte presented
    for (int i = 0; i < 2; i++) begin
      in_data = 8'($urandom_range(0, 255));
      cycle("t4fill", acc);
    end
    check("t4:sel3", sel, 3'd3);
    clr = 1'b1; in_data = 8'h55;
    cycle("t4clr", acc);
    clr = 1'b0; in_valid = 1'b0;
    check("t4:sel0", sel, 3'd0);
    check("t4:out0_not55", outs[0], 8'h00);

    // 3: random gaps, 16 bytes, BLK_READY tied high
    blk_ready = 1'b1; n_acc = 0; budget = 400; full_cycles = 0;
    while ((n_acc < 16 || m_filled == 8) && budget > 0) begin
      budget--;
      in_valid = (n_acc < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      cycle("t3", acc);
      if (acc) begin
        exp_q.push_back(in_data);
        n_acc++;
      end
      if (blk_valid) begin
        full_cycles++;
        for (int i = 0; i < 8; i++) begin
          last_blk[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check($sformatf("t3:sb_out%0d", i), outs[i], last_blk[i]);
        end
      end
    end
    check("t3:budget_ok", (budget > 0), 1'b1);
    check("t3:bubbles", full_cycles, 2);
    blk_ready = 1'b0;

    // 6: partial refill of two bytes
    in_valid = 1'b1; in_data = 8'hF0; cycle("t6", acc);
    in_data = 8'hF1; cycle("t6", acc);
    in_valid = 1'b0;
    check("t6:out0", outs[0], 8'hF0);
    check("t6:out1", outs[1], 8'hF1);
    for (int i = 2; i < 8; i++)
      check($sformatf("t6:keep%0d", i), outs[i], last_blk[i]);
    check("t6:blk_valid", blk_valid, 1'b0);

    // 5: async reset while FULL
    in_valid = 1'b1; budget = 20;
    while (m_filled != 8 && budget > 0) begin
      budget--;
      in_data = 8'($urandom_range(0, 255));
      cycle("t5fill", acc);
    end
    in_valid = 1'b0;
    check("t5:full_reached", blk_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5async");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h20 + i);
      cycle("t5resume", acc);
    end
    in_valid = 1'b0;
    check("t5:out7", outs[7], 8'h27);
    blk_ready = 1'b1; cycle("t5ho", acc);
    blk_ready = 1'b0; cycle("t5idle", acc);

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
    $finish;
  end

endmodule
